// File: rtl/sram_req_arbiter_if.sv
// rtl/sram_req_arbiter_if.sv - fetch/data requester and memory-side handshake bundle for sram_req_arbiter
interface sram_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic                data_req;
    logic                data_wr;
    logic [1:0]          data_size;
    logic [ADDR_W-1:0]   data_addr;
    logic [DATA_W/8-1:0] data_wstrb;
    logic [DATA_W-1:0]   data_wdata;
    logic                data_addr_ok;
    logic                data_data_ok;
    logic [DATA_W-1:0]   data_rdata;

    logic                mem_req;
    logic                mem_wr;
    logic [1:0]          mem_size;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_addr_ok;
    logic                mem_data_ok;
    logic [DATA_W-1:0]   mem_rdata;

    // master is the arbiter; slave is the surrounding requesters plus memory bridge
    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - fetch/data arbiter onto one SRAM-like port with in-order response routing; SRAM_ARB_RR_EN enables round-robin grant
module sram_req_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int OUTS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    sram_req_arbiter_if.master             bus,
    output logic [$clog2(OUTS_DEPTH):0]    outstanding,
    output logic                           err_unexp_ok
);
    localparam int PTR_W = $clog2(OUTS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [OUTS_DEPTH-1:0] owner_q;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      outs_q;
    logic                  err_q;
    logic                  full;
    logic                  grant_data;
    logic                  push;
    logic                  pop;
    logic                  head_data;

    assign full = (outs_q == CNT_W'(OUTS_DEPTH));

`ifdef SRAM_ARB_RR_EN
    logic last_grant_q;

    // with both requesters active, hand the port to whoever did not win last
    assign grant_data = bus.data_req & (~bus.inst_req | ~last_grant_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant_q <= 1'b0;
        end else if (push) begin
            last_grant_q <= grant_data;
        end
    end
`else
    assign grant_data = bus.data_req;
`endif

    // gated by resetn so no request leaks out while the block is held in reset
    assign bus.mem_req   = resetn & (bus.inst_req | bus.data_req) & ~full;
    assign bus.mem_wr    = grant_data ? bus.data_wr    : 1'b0;
    assign bus.mem_size  = grant_data ? bus.data_size  : 2'd2;
    assign bus.mem_addr  = grant_data ? bus.data_addr  : bus.inst_addr;
    assign bus.mem_wstrb = grant_data ? bus.data_wstrb : '0;
    assign bus.mem_wdata = grant_data ? bus.data_wdata : '0;

    assign push = bus.mem_req & bus.mem_addr_ok;
    assign pop  = resetn & bus.mem_data_ok & (outs_q != '0);

    assign bus.inst_addr_ok = push & ~grant_data;
    assign bus.data_addr_ok = push & grant_data;

    assign head_data         = owner_q[rd_ptr];
    assign bus.inst_data_ok  = pop & ~head_data;
    assign bus.data_data_ok  = pop & head_data;
    assign bus.inst_rdata    = bus.mem_rdata;
    assign bus.data_rdata    = bus.mem_rdata;

    assign outstanding  = outs_q;
    assign err_unexp_ok = err_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            outs_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                owner_q[wr_ptr] <= grant_data;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   outs_q <= outs_q + CNT_W'(1);
                2'b01:   outs_q <= outs_q - CNT_W'(1);
                default: outs_q <= outs_q;
            endcase
            if (bus.mem_data_ok && outs_q == '0) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - scoreboard bench for sram_req_arbiter
module tb_sram_req_arbiter;
    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] outstanding;
    logic       err_unexp_ok;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [32:0] exp_q[$];
    logic [2:0]  pat;

    sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_req_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTS_DEPTH(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .outstanding  (outstanding),
        .err_unexp_ok (err_unexp_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every response the DUT presents is matched against the scoreboard head
    always @(negedge clk) begin
        if (bus.inst_data_ok || bus.data_data_ok) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", {bus.inst_data_ok, bus.data_data_ok}, 64'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("resp_route", {bus.inst_data_ok, bus.data_data_ok}, e[32] ? 64'd1 : 64'd2);
                chk("resp_rdata", bus.data_data_ok ? bus.data_rdata : bus.inst_rdata, {32'd0, e[31:0]});
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.inst_req = 0; bus.inst_addr = '0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_size = 2'd2; bus.data_addr = '0;
        bus.data_wstrb = '0; bus.data_wdata = '0;
        bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = '0;
    endtask

    task automatic respond(input logic [31:0] rd, input logic own);
        exp_q.push_back({own, rd});
        bus.mem_data_ok = 1; bus.mem_rdata = rd;
        cyc;
        bus.mem_data_ok = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef SRAM_ARB_RR_EN
        pat = 3'b101;
`else
        pat = 3'b111;
`endif
        idle;
        resetn = 0; bus.inst_req = 1;
        @(negedge clk);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_inst_addr_ok", bus.inst_addr_ok, 0);
        cyc; resetn = 1; bus.inst_req = 0;
        @(negedge clk);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_unexp_ok, 0);
        chk("idle_mem_req", bus.mem_req, 0);

        // single fetch
        cyc; bus.inst_req = 1; bus.inst_addr = 32'h1c000000; bus.mem_addr_ok = 1;
        @(negedge clk);
        chk("f_inst_addr_ok", bus.inst_addr_ok, 1);
        chk("f_data_addr_ok", bus.data_addr_ok, 0);
        chk("f_mem_addr", bus.mem_addr, 32'h1c000000);
        chk("f_mem_size", bus.mem_size, 2);
        chk("f_mem_wr", bus.mem_wr, 0);
        cyc; bus.inst_req = 0; bus.mem_addr_ok = 0;
        @(negedge clk);
        chk("f_outstanding1", outstanding, 1);
        cyc;
        respond(32'h02800c0c, 1'b0);
        @(negedge clk);
        chk("f_outstanding0", outstanding, 0);

        // contention
        cyc;
        bus.inst_req = 1; bus.inst_addr = 32'h1c000010;
        bus.data_req = 1; bus.data_wr = 1; bus.data_size = 2'd2; bus.data_addr = 32'h8;
        bus.data_wstrb = 4'hf; bus.data_wdata = 32'hdeadbeef; bus.mem_addr_ok = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("c_data_addr_ok", bus.data_addr_ok, pat[i]);
            chk("c_inst_addr_ok", bus.inst_addr_ok, !pat[i]);
            chk("c_mem_wdata", bus.mem_wdata, pat[i] ? 32'hdeadbeef : 32'h0);
            chk("c_mem_wstrb", bus.mem_wstrb, pat[i] ? 4'hf : 4'h0);
            cyc;
        end
        idle;
        @(negedge clk);
        chk("c_outstanding3", outstanding, 3);
        cyc;
        for (int i = 0; i < 3; i++) respond(32'h10 + i, pat[i]);
        @(negedge clk);
        chk("c_outstanding0", outstanding, 0);

        // order routing: inst, data, inst
        cyc;
        for (int i = 0; i < 3; i++) begin
            bus.inst_req = (i != 1); bus.data_req = (i == 1); bus.data_wr = 0;
            bus.inst_addr = 32'h100 + i * 4; bus.data_addr = 32'h200; bus.mem_addr_ok = 1;
            @(negedge clk);
            chk("o_addr_ok", {bus.inst_addr_ok, bus.data_addr_ok}, (i == 1) ? 64'd1 : 64'd2);
            cyc;
        end
        idle;
        respond(32'd1, 1'b0);
        respond(32'd2, 1'b1);
        respond(32'd3, 1'b0);

        // full
        bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h300; bus.mem_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("u_data_addr_ok", bus.data_addr_ok, 1);
            cyc;
        end
        @(negedge clk);
        chk("u_mem_req_full", bus.mem_req, 0);
        chk("u_outstanding4", outstanding, 4);
        cyc;
        exp_q.push_back({1'b1, 32'h40});
        bus.mem_data_ok = 1; bus.mem_rdata = 32'h40;
        @(negedge clk);
        chk("u_nopush_pop", bus.data_addr_ok, 0);
        cyc; bus.mem_data_ok = 0;
        @(negedge clk);
        chk("u_outstanding3", outstanding, 3);
        chk("u_push_next", bus.data_addr_ok, 1);
        cyc; bus.data_req = 0; bus.mem_addr_ok = 0;
        @(negedge clk);
        chk("u_refill4", outstanding, 4);
        cyc;
        for (int i = 0; i < 4; i++) respond(32'h41 + i, 1'b1);
        @(negedge clk);
        chk("u_drained", outstanding, 0);

        // stray response
        cyc;
        bus.mem_data_ok = 1; bus.mem_rdata = 32'h55;
        @(negedge clk);
        chk("s_no_route", {bus.inst_data_ok, bus.data_data_ok}, 0);
        cyc; bus.mem_data_ok = 0;
        @(negedge clk);
        chk("s_err", err_unexp_ok, 1);
        chk("s_outstanding", outstanding, 0);
        cyc;
        @(negedge clk);
        chk("s_err_sticky", err_unexp_ok, 1);

        // reset mid-operation
        cyc;
        bus.inst_req = 1; bus.inst_addr = 32'h1c000020; bus.mem_addr_ok = 1;
        cyc; cyc; cyc;
        bus.mem_addr_ok = 0;
        @(negedge clk);
        chk("r_outstanding3", outstanding, 3);
        cyc; resetn = 0; bus.mem_addr_ok = 1;
        @(negedge clk);
        chk("r_mem_req_in_rst", bus.mem_req, 0);
        cyc;
        @(negedge clk);
        chk("r_outstanding0", outstanding, 0);
        cyc; resetn = 1; bus.inst_addr = 32'h1c000004;
        @(negedge clk);
        chk("r_new_fetch_ok", bus.inst_addr_ok, 1);
        chk("r_err_cleared", err_unexp_ok, 0);
        cyc; bus.inst_req = 0; bus.mem_addr_ok = 0;
        @(negedge clk);
        chk("r_outstanding1", outstanding, 1);
        cyc;
        respond(32'h00000abc, 1'b0);
        @(negedge clk);
        chk("r_outstanding_end", outstanding, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (read-only) and the data requester (EX-stage load/store).
- Downstream handshake: req/addr_ok for requests, data_ok for responses.
- Records which requester owns each accepted request in an in-order ownership FIFO and routes each data_ok/rdata back to that requester.
- Sits between the IF/EX stages and the memory bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (DATA_W/8 strobe bits)
OUTS_DEPTH, 4, maximum outstanding requests; power of two, >= 2

Ports:
clk  in  1  clock
resetn  in  1  reset
inst_req  in  1  fetch request
inst_addr  in  ADDR_W  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch response valid
inst_rdata  out  DATA_W  fetch read data
data_req  in  1  load/store request
data_wr  in  1  1 = store
data_size  in  2  0 byte, 1 half, 2 word
data_addr  in  ADDR_W  load/store address
data_wstrb  in  DATA_W/8  byte-write strobes
data_wdata  in  DATA_W  store data
data_addr_ok  out  1  load/store request accepted this cycle
data_data_ok  out  1  load/store response valid (also returned for stores)
data_rdata  out  DATA_W  load data
mem_req  out  1  downstream request
mem_wr  out  1  downstream write
mem_size  out  2  downstream size
mem_addr  out  ADDR_W  downstream address
mem_wstrb  out  DATA_W/8  downstream strobes
mem_wdata  out  DATA_W  downstream write data
mem_addr_ok  in  1  downstream request accepted
mem_data_ok  in  1  downstream response valid
mem_rdata  in  DATA_W  downstream read data
outstanding  out  $clog2(OUTS_DEPTH)+1  number of accepted, unanswered requests
err_unexp_ok  out  1  sticky flag: mem_data_ok received with nothing outstanding

Behaviour:
- Reset: resetn is synchronous, active-low, clock clk. Reset empties the FIFO, sets outstanding=0, clears err_unexp_ok and sets last_grant=inst.
  - All outputs are combinational from these registers, so mem_req, inst_addr_ok and data_addr_ok are 0 during reset.
  - Reset mid-transaction drops ownership of in-flight responses; the memory side is reset together with this block.
- Full condition: full = (outstanding == OUTS_DEPTH). Push is blocked when full, even if a pop occurs in the same cycle.
- Arbitration (combinational):
  - mem_req = (inst_req | data_req) & ~full.
  - Default fixed priority: the data requester wins whenever data_req=1.
  - The granted requester's attributes drive the mem_* outputs.
  - An inst grant forces mem_wr=0, mem_size=2, mem_wstrb=0 and mem_wdata=0.
- Request acceptance: xx_addr_ok = granted & mem_req & mem_addr_ok; the non-granted requester sees addr_ok=0.
- Request stability: requesters hold req and attributes until accepted. The grant may switch while the accept is pending (for example, data_req rises); this is legal because no handshake has happened yet.
- Push: on mem_req & mem_addr_ok, push the owner ID (0 inst, 1 data) at wr_ptr and increment wr_ptr modulo OUTS_DEPTH.
- Pop: on mem_data_ok with outstanding>0:
  - head ID selects the responder: inst_data_ok or data_data_ok = 1 for one cycle.
  - inst_rdata and data_rdata both equal mem_rdata.
  - Increment rd_ptr.
- Response ordering: responses return in acceptance order. Same-cycle push and pop are allowed when not full; outstanding is then unchanged.
- Unexpected response: mem_data_ok with outstanding==0 sets err_unexp_ok, routes to no requester and leaves the pointers unchanged.
- Latency: zero-cycle combinational pass-through in both directions; no added registers.
- Occupancy: outstanding increments on push-only, decrements on pop-only and never wraps.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: when both requesters are active, the grant goes to the requester that was not last_grant. last_grant updates only on an accepted handshake. A single requester is always granted.
- Undefined: fixed data-over-inst priority; the last_grant register is absent.

Test Plan:
- Single fetch: inst_req=1, addr=0x1c000000, mem_addr_ok=1 -> inst_addr_ok=1 and outstanding=1. mem_data_ok with rdata=0x02800c0c two cycles later -> inst_data_ok=1, inst_rdata=0x02800c0c, outstanding=0.
- Contention: inst_req=1 and data_req=1 (store, addr 0x8, wstrb 0xF, wdata 0xdeadbeef) with mem_addr_ok=1.
  - Without SRAM_ARB_RR_EN -> data wins for 3 consecutive cycles while data_req holds.
  - With SRAM_ARB_RR_EN -> grants alternate data, inst, data.
- Order routing: accept inst, data, inst; answer with rdata 1, 2, 3 -> inst_data_ok then data_data_ok then inst_data_ok; data_rdata=2.
- Full: 4 accepted and none returned (OUTS_DEPTH=4) -> mem_req=0 despite requests and outstanding=4. A same-cycle data_ok -> no push that cycle; the push happens the next cycle.
- Stray response: mem_data_ok with outstanding=0 -> err_unexp_ok=1 (sticky until reset), no requester data_ok.
- Reset mid-operation: resetn=0 with 3 outstanding -> outstanding=0 and mem_req=0 next cycle. A new fetch after release works normally.
